// File: rtl/draw_scheduler.sv
// Command queue and sequencer for the circle engine, with a full-screen clear sweep.
// Owns the VGA plot bus and hands it to the engine only while a circle is running.
module draw_scheduler #(
    parameter int          DEPTH        = 4,
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [7:0] i_cmd_x,
    input  logic [6:0] i_cmd_y,
    input  logic [7:0] i_cmd_r,
    input  logic [2:0] i_cmd_colour,
    input  logic       i_clear_req,
    output logic       o_busy,
    output logic       o_circ_start,
    input  logic       i_circ_done,
    output logic [7:0] o_circ_centre_x,
    output logic [6:0] o_circ_centre_y,
    output logic [7:0] o_circ_radius,
    output logic [2:0] o_circ_colour,
    input  logic [7:0] i_circ_vga_x,
    input  logic [6:0] i_circ_vga_y,
    input  logic [2:0] i_circ_vga_colour,
    input  logic       i_circ_vga_plot,
    output logic [7:0] o_vga_x,
    output logic [6:0] o_vga_y,
    output logic [2:0] o_vga_colour,
    output logic       o_vga_plot
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [7:0]     SX_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0]     SY_LAST  = 7'(SCREEN_H - 1);

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] r;
        logic [2:0] colour;
    } cmd_t;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_LOAD, S_RUN, S_RELEASE} state_t;

    state_t        r_state;
    state_t        w_next;
    cmd_t          r_mem [DEPTH];
    cmd_t          r_circ;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_clear_pending;
    logic          r_circ_start;
    logic [7:0]    r_sx;
    logic [6:0]    r_sy;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_go_clear;
    logic w_sweep_last;

    // Full is judged on the registered count alone, so a same-cycle pop never frees a slot.
    assign w_full       = (r_count == FULL_CNT);
    assign w_empty      = (r_count == '0);
    assign w_push       = i_cmd_valid && !w_full;
    assign w_go_clear   = (r_state == S_IDLE) && r_clear_pending;
    assign w_pop        = (r_state == S_IDLE) && !r_clear_pending && !w_empty;
    assign w_sweep_last = (r_sx == SX_LAST) && (r_sy == SY_LAST);

    assign o_cmd_ready     = !w_full;
    assign o_busy          = (r_state != S_IDLE) || !w_empty || r_clear_pending;
    assign o_circ_start    = r_circ_start;
    assign o_circ_centre_x = r_circ.x;
    assign o_circ_centre_y = r_circ.y;
    assign o_circ_radius   = r_circ.r;
    assign o_circ_colour   = r_circ.colour;

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_go_clear)  w_next = S_CLEAR;
                else if (w_pop)  w_next = S_LOAD;
            end
            S_CLEAR:   if (w_sweep_last) w_next = S_IDLE;
            S_LOAD:    w_next = S_RUN;
            S_RUN:     if (i_circ_done) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_vga_x      = '0;
        o_vga_y      = '0;
        o_vga_colour = '0;
        o_vga_plot   = 1'b0;
        if (r_state == S_CLEAR) begin
            o_vga_x      = r_sx;
            o_vga_y      = r_sy;
            o_vga_colour = CLEAR_COLOUR;
            o_vga_plot   = 1'b1;
        end else if (r_state == S_RUN) begin
            o_vga_x      = i_circ_vga_x;
            o_vga_y      = i_circ_vga_y;
            o_vga_colour = i_circ_vga_colour;
            o_vga_plot   = i_circ_vga_plot;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state         <= S_IDLE;
            r_circ_start    <= 1'b0;
            r_clear_pending <= 1'b0;
            r_circ          <= '0;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_sx            <= '0;
            r_sy            <= '0;
        end else begin
            r_state      <= w_next;
            r_circ_start <= (w_next == S_RUN);

            // A request arriving on the clear transition itself keeps the flag for a second sweep.
            if (i_clear_req)     r_clear_pending <= 1'b1;
            else if (w_go_clear) r_clear_pending <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_circ   <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase

            if (w_go_clear) begin
                r_sx <= '0;
                r_sy <= '0;
            end else if (r_state == S_CLEAR) begin
                if (r_sx == SX_LAST) begin
                    r_sx <= '0;
                    r_sy <= r_sy + 7'd1;
                end else begin
                    r_sx <= r_sx + 8'd1;
                end
            end
        end
    end

    // NOTE: queue storage is not reset; resetting the pointers and count is what flushes it.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= '{x: i_cmd_x, y: i_cmd_y, r: i_cmd_r, colour: i_cmd_colour};
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: expected circles and clear pixels are queued at
// stimulus time and popped by a bus monitor; an engine model answers circ_start.
module tb_draw_scheduler;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [7:0] r;
        logic [2:0] colour;
    } cmd_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_x;
    logic [6:0] i_cmd_y;
    logic [7:0] i_cmd_r;
    logic [2:0] i_cmd_colour;
    logic       i_clear_req;
    logic       o_busy;
    logic       o_circ_start;
    logic       i_circ_done;
    logic [7:0] o_circ_centre_x;
    logic [6:0] o_circ_centre_y;
    logic [7:0] o_circ_radius;
    logic [2:0] o_circ_colour;
    logic [7:0] i_circ_vga_x;
    logic [6:0] i_circ_vga_y;
    logic [2:0] i_circ_vga_colour;
    logic       i_circ_vga_plot;
    logic [7:0] o_vga_x;
    logic [6:0] o_vga_y;
    logic [2:0] o_vga_colour;
    logic       o_vga_plot;

    int    n_checks = 0;
    int    n_fail   = 0;
    cmd_t  exp_cmds[$];
    pix_t  exp_pix[$];
    string ev_log;

    bit    eng_hold = 1'b0;
    int    eng_len  = 10;
    int    eng_cnt  = 0;

    draw_scheduler dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_cmd_valid      (i_cmd_valid),
        .o_cmd_ready      (o_cmd_ready),
        .i_cmd_x          (i_cmd_x),
        .i_cmd_y          (i_cmd_y),
        .i_cmd_r          (i_cmd_r),
        .i_cmd_colour     (i_cmd_colour),
        .i_clear_req      (i_clear_req),
        .o_busy           (o_busy),
        .o_circ_start     (o_circ_start),
        .i_circ_done      (i_circ_done),
        .o_circ_centre_x  (o_circ_centre_x),
        .o_circ_centre_y  (o_circ_centre_y),
        .o_circ_radius    (o_circ_radius),
        .o_circ_colour    (o_circ_colour),
        .i_circ_vga_x     (i_circ_vga_x),
        .i_circ_vga_y     (i_circ_vga_y),
        .i_circ_vga_colour(i_circ_vga_colour),
        .i_circ_vga_plot  (i_circ_vga_plot),
        .o_vga_x          (o_vga_x),
        .o_vga_y          (o_vga_y),
        .o_vga_colour     (o_vga_colour),
        .o_vga_plot       (o_vga_plot)
    );

    always #5 clk = ~clk;

    // Circle engine model: plots a pattern while started, raises done after eng_len cycles.
    always @(posedge clk) begin
        #1;
        if (!o_circ_start) begin
            eng_cnt         = 0;
            i_circ_done     = 1'b0;
            i_circ_vga_plot = 1'b0;
        end else begin
            eng_cnt++;
            i_circ_done       = !eng_hold && (eng_cnt >= eng_len);
            i_circ_vga_plot   = (eng_cnt % 4) != 0;
            i_circ_vga_x      = 8'(eng_cnt);
            i_circ_vga_y      = 7'(eng_cnt * 3);
            i_circ_vga_colour = 3'(eng_cnt + 1);
        end
    end

    // Bus monitor / scoreboard consumer.
    bit   prev_start = 1'b0;
    bit   prev_clear = 1'b0;
    cmd_t cur_cmd;
    pix_t got_pix;

    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            prev_clear = 1'b0;
        end else begin
            if (o_circ_start) begin
                if (!prev_start) begin
                    ev_log = {ev_log, "R"};
                    n_checks++;
                    if (exp_cmds.size() == 0) begin
                        n_fail++;
                        $display("FAIL circle_unexpected: start seen with params %h/%h/%h/%h, required no circle",
                                 o_circ_centre_x, o_circ_centre_y, o_circ_radius, o_circ_colour);
                        cur_cmd = '{x: o_circ_centre_x, y: o_circ_centre_y, r: o_circ_radius, colour: o_circ_colour};
                    end else begin
                        cur_cmd = exp_cmds.pop_front();
                    end
                end
                n_checks++;
                if ({o_circ_centre_x, o_circ_centre_y, o_circ_radius, o_circ_colour} !== cur_cmd) begin
                    n_fail++;
                    $display("FAIL circle_params: got %h/%h/%h/%h, required %h/%h/%h/%h",
                             o_circ_centre_x, o_circ_centre_y, o_circ_radius, o_circ_colour,
                             cur_cmd.x, cur_cmd.y, cur_cmd.r, cur_cmd.colour);
                end
                n_checks++;
                if ({o_vga_x, o_vga_y, o_vga_colour, o_vga_plot} !==
                    {i_circ_vga_x, i_circ_vga_y, i_circ_vga_colour, i_circ_vga_plot}) begin
                    n_fail++;
                    $display("FAIL vga_passthrough: got %h,%h,%h,%b required %h,%h,%h,%b",
                             o_vga_x, o_vga_y, o_vga_colour, o_vga_plot,
                             i_circ_vga_x, i_circ_vga_y, i_circ_vga_colour, i_circ_vga_plot);
                end
                prev_clear = 1'b0;
            end else if (o_vga_plot) begin
                if (!prev_clear) ev_log = {ev_log, "C"};
                n_checks++;
                if (exp_pix.size() == 0) begin
                    n_fail++;
                    $display("FAIL clear_unexpected: plot at %0d,%0d, required none", o_vga_x, o_vga_y);
                end else begin
                    got_pix = exp_pix.pop_front();
                    if (o_vga_x !== got_pix.x || o_vga_y !== got_pix.y || o_vga_colour !== 3'b000) begin
                        n_fail++;
                        $display("FAIL clear_pixel: got %0d,%0d c%0d, required %0d,%0d c0",
                                 o_vga_x, o_vga_y, o_vga_colour, got_pix.x, got_pix.y);
                    end
                end
                prev_clear = 1'b1;
            end else begin
                n_checks++;
                if (o_vga_x !== 8'd0 || o_vga_y !== 7'd0 || o_vga_colour !== 3'd0) begin
                    n_fail++;
                    $display("FAIL idle_bus: got %h,%h,%h, required 0,0,0", o_vga_x, o_vga_y, o_vga_colour);
                end
                prev_clear = 1'b0;
            end
            prev_start = o_circ_start;
        end
    end

    task automatic push_cmd(input logic [7:0] x, input logic [6:0] y,
                            input logic [7:0] r, input logic [2:0] c);
        bit accepted = 1'b0;
        i_cmd_valid  = 1'b1;
        i_cmd_x      = x;
        i_cmd_y      = y;
        i_cmd_r      = r;
        i_cmd_colour = c;
        for (int i = 0; i < 2000 && !accepted; i++) begin
            accepted = o_cmd_ready;
            @(posedge clk);
            #1;
        end
        i_cmd_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL push_timeout: cmd_ready never 1, required acceptance");
        end else begin
            exp_cmds.push_back('{x: x, y: y, r: r, colour: c});
        end
    endtask

    task automatic expect_sweep();
        for (int sy = 0; sy < 120; sy++)
            for (int sx = 0; sx < 160; sx++)
                exp_pix.push_back('{x: 8'(sx), y: 7'(sy)});
    endtask

    task automatic pulse_clear();
        i_clear_req = 1'b1;
        @(posedge clk);
        #1;
        i_clear_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = !o_busy;
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            #1;
            ok = o_circ_start;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        i_cmd_valid  = 1'b0;
        i_cmd_x      = '0;
        i_cmd_y      = '0;
        i_cmd_r      = '0;
        i_cmd_colour = '0;
        i_clear_req  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({o_cmd_ready, o_busy, o_circ_start, o_vga_plot} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_flags: ready/busy/start/plot=%b, required 1000",
                     {o_cmd_ready, o_busy, o_circ_start, o_vga_plot});
        end
        n_checks++;
        if ({o_vga_x, o_vga_y, o_vga_colour} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_vga: %h,%h,%h required 0", o_vga_x, o_vga_y, o_vga_colour);
        end
        n_checks++;
        if ({o_circ_centre_x, o_circ_centre_y, o_circ_radius, o_circ_colour} !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_params: %h/%h/%h/%h required 0",
                     o_circ_centre_x, o_circ_centre_y, o_circ_radius, o_circ_colour);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_circle();
        bit ok;
        bit seen_done = 1'b0;
        ev_log  = "";
        eng_len = 100;
        push_cmd(8'd80, 7'd60, 8'd20, 3'b010);
        n_checks++;
        if (o_circ_start !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_e0: circ_start=%b, required 0", o_circ_start);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (o_circ_start !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_e1: circ_start=%b, required 0", o_circ_start);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (o_circ_start !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_e2: circ_start=%b, required 1", o_circ_start);
        end
        for (int i = 0; i < 300 && !seen_done; i++) begin
            @(negedge clk);
            seen_done = i_circ_done;
        end
        n_checks++;
        if (!seen_done) begin
            n_fail++;
            $display("FAIL engine_done_timeout: done never seen, required within 300 cycles");
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (o_circ_start !== 1'b0) begin
            n_fail++;
            $display("FAIL release_start: circ_start=%b, required 0", o_circ_start);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy: busy=%b, required 0", o_busy);
        end
        wait_idle(10, ok);
        n_checks++;
        if (ev_log != "R" || exp_cmds.size() != 0) begin
            n_fail++;
            $display("FAIL single_order: log=%s left=%0d, required R left=0", ev_log, exp_cmds.size());
        end
    endtask

    task automatic test_clear();
        bit ok;
        ev_log = "";
        expect_sweep();
        pulse_clear();
        wait_idle(20000, ok);
        n_checks++;
        if (!ok || exp_pix.size() != 0 || ev_log != "C") begin
            n_fail++;
            $display("FAIL clear_sweep: idle=%b left=%0d log=%s, required 1, 0, C", ok, exp_pix.size(), ev_log);
        end
        n_checks++;
        if (o_vga_plot !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_after: vga_plot=%b, required 0", o_vga_plot);
        end
    endtask

    task automatic test_fifo_full();
        bit ok;
        ev_log   = "";
        eng_hold = 1'b1;
        eng_len  = 5;
        push_cmd(8'd10, 7'd11, 8'd12, 3'd1);
        wait_start(10, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fifo_first_start: circ_start never 1, required 1");
        end
        for (int i = 0; i < 4; i++) begin
            push_cmd(8'(20 + 10 * i), 7'(30 + i), 8'(5 + i), 3'(i + 2));
            n_checks++;
            if (o_cmd_ready !== (i < 3)) begin
                n_fail++;
                $display("FAIL fifo_ready_%0d: cmd_ready=%b, required %b", i, o_cmd_ready, (i < 3));
            end
        end
        i_cmd_valid = 1'b1;
        i_cmd_x     = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (o_cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL fifo_hold_full: cmd_ready=%b, required 0", o_cmd_ready);
            end
        end
        i_cmd_valid = 1'b0;
        eng_hold    = 1'b0;
        wait_idle(2000, ok);
        n_checks++;
        if (!ok || exp_cmds.size() != 0 || ev_log != "RRRRR") begin
            n_fail++;
            $display("FAIL fifo_order: idle=%b left=%0d log=%s, required 1, 0, RRRRR", ok, exp_cmds.size(), ev_log);
        end
    endtask

    task automatic test_clear_between();
        bit ok;
        ev_log  = "";
        eng_len = 20;
        push_cmd(8'd40, 7'd50, 8'd9, 3'd4);
        push_cmd(8'd41, 7'd51, 8'd7, 3'd5);
        wait_start(10, ok);
        expect_sweep();
        pulse_clear();
        wait_idle(20000, ok);
        n_checks++;
        if (!ok || ev_log != "RCR" || exp_pix.size() != 0 || exp_cmds.size() != 0) begin
            n_fail++;
            $display("FAIL clear_between: idle=%b log=%s pix=%0d cmds=%0d, required 1, RCR, 0, 0",
                     ok, ev_log, exp_pix.size(), exp_cmds.size());
        end
    endtask

    task automatic test_clear_during_clear();
        bit ok;
        ev_log = "";
        expect_sweep();
        pulse_clear();
        repeat (500) @(posedge clk);
        #1;
        n_checks++;
        if (o_vga_plot !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_active: vga_plot=%b, required 1", o_vga_plot);
        end
        expect_sweep();
        pulse_clear();
        wait_idle(40000, ok);
        n_checks++;
        if (!ok || ev_log != "CC" || exp_pix.size() != 0) begin
            n_fail++;
            $display("FAIL double_clear: idle=%b log=%s left=%0d, required 1, CC, 0", ok, ev_log, exp_pix.size());
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        bit saw_start = 1'b0;
        ev_log   = "";
        eng_hold = 1'b1;
        push_cmd(8'd90, 7'd91, 8'd30, 3'd6);
        push_cmd(8'd92, 7'd93, 8'd31, 3'd7);
        push_cmd(8'd94, 7'd95, 8'd32, 3'd3);
        wait_start(10, ok);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_cmds.delete();
        n_checks++;
        if ({o_circ_start, o_vga_plot, o_cmd_ready, o_busy} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_mid_run: start/plot/ready/busy=%b, required 0010",
                     {o_circ_start, o_vga_plot, o_cmd_ready, o_busy});
        end
        @(negedge clk);
        rst      = 1'b0;
        eng_hold = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (o_circ_start) saw_start = 1'b1;
        end
        n_checks++;
        if (saw_start || o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_flush: start_seen=%b busy=%b ready=%b, required 0,0,1",
                     saw_start, o_busy, o_cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_circle();
        test_clear();
        test_fifo_full();
        test_clear_between();
        test_clear_during_clear();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
